jvm_bytecode_decoder: RTL and testbench

- Decode stage of the JVM bytecode core: accepts one 32-bit fetched word (opcode in bits 31:24, operand bytes below).
- Classifies the opcode, extracts length and immediate, and forwards a packed decode word to the memory/execute stage.
- Uses start/ready handshakes on both sides and exports FSM debug signals.

---
 rtl/jvm_decoder_pkg.sv | 72 +++++++
 rtl/jvm_opcode_classifier.sv | 102 ++++++++++
 rtl/jvm_bytecode_decoder.sv | 127 ++++++++++++
 tb/tb_jvm_bytecode_decoder.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/jvm_decoder_pkg.sv
// Shared definitions for the JVM bytecode decode stage: FSM encoding, class
// codes, decode-word field positions and opcode range boundaries.
package jvm_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_SEND   = 2'd2,
    ST_DONE   = 2'd3
  } dec_state_e;

  localparam logic [3:0] CLS_NOP         = 4'h0;
  localparam logic [3:0] CLS_CONST       = 4'h1;
  localparam logic [3:0] CLS_LOAD        = 4'h2;
  localparam logic [3:0] CLS_STORE       = 4'h3;
  localparam logic [3:0] CLS_ALOAD       = 4'h4;
  localparam logic [3:0] CLS_ASTORE      = 4'h5;
  localparam logic [3:0] CLS_STACK       = 4'h6;
  localparam logic [3:0] CLS_ARITH       = 4'h7;
  localparam logic [3:0] CLS_CONVERT     = 4'h8;
  localparam logic [3:0] CLS_COMPARE     = 4'h9;
  localparam logic [3:0] CLS_BRANCH      = 4'hA;
  localparam logic [3:0] CLS_IINC        = 4'hB;
  localparam logic [3:0] CLS_UNSUPPORTED = 4'hF;

  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 24;
  localparam int VALID_BIT = 17;

  localparam logic [7:0] OP_NOP         = 8'h00;
  localparam logic [7:0] OP_ACONST_NULL = 8'h01;
  localparam logic [7:0] OP_ICONST_LO   = 8'h02;
  localparam logic [7:0] OP_ICONST_HI   = 8'h08;
  localparam logic [7:0] OP_LCONST_LO   = 8'h09;
  localparam logic [7:0] OP_FCONST_LO   = 8'h0B;
  localparam logic [7:0] OP_DCONST_LO   = 8'h0E;
  localparam logic [7:0] OP_DCONST_HI   = 8'h0F;
  localparam logic [7:0] OP_BIPUSH      = 8'h10;
  localparam logic [7:0] OP_SIPUSH      = 8'h11;
  localparam logic [7:0] OP_LOAD_LO     = 8'h15;
  localparam logic [7:0] OP_LOAD_HI     = 8'h19;
  localparam logic [7:0] OP_LOADN_LO    = 8'h1A;
  localparam logic [7:0] OP_LOADN_HI    = 8'h2D;
  localparam logic [7:0] OP_ALOAD_LO    = 8'h2E;
  localparam logic [7:0] OP_ALOAD_HI    = 8'h35;
  localparam logic [7:0] OP_STORE_LO    = 8'h36;
  localparam logic [7:0] OP_STORE_HI    = 8'h3A;
  localparam logic [7:0] OP_STOREN_LO   = 8'h3B;
  localparam logic [7:0] OP_STOREN_HI   = 8'h4E;
  localparam logic [7:0] OP_ASTORE_LO   = 8'h4F;
  localparam logic [7:0] OP_ASTORE_HI   = 8'h56;
  localparam logic [7:0] OP_STACK_LO    = 8'h57;
  localparam logic [7:0] OP_STACK_HI    = 8'h5F;
  localparam logic [7:0] OP_ARITH_LO    = 8'h60;
  localparam logic [7:0] OP_ARITH_HI    = 8'h83;
  localparam logic [7:0] OP_IINC        = 8'h84;
  localparam logic [7:0] OP_CONV_LO     = 8'h85;
  localparam logic [7:0] OP_CONV_HI     = 8'h93;
  localparam logic [7:0] OP_CMP_LO      = 8'h94;
  localparam logic [7:0] OP_CMP_HI      = 8'h98;
  localparam logic [7:0] OP_BRANCH_LO   = 8'h99;
  localparam logic [7:0] OP_BRANCH_HI   = 8'hA8;

  function automatic logic [31:0] pack_decode(input logic [7:0]  opcode,
                                              input logic [3:0]  cls,
                                              input logic [1:0]  len,
                                              input logic        valid,
                                              input logic [15:0] imm);
    return {opcode, cls, len, valid, 1'b0, imm};
  endfunction

endpackage

// File: rtl/jvm_opcode_classifier.sv
// Purely combinational opcode classifier: fetched word in, class, length,
// valid flag and 16-bit immediate out.
module jvm_opcode_classifier
  import jvm_decoder_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  cls,
  output logic [1:0]  length,
  output logic        valid,
  output logic [15:0] imm
);

  logic [7:0] op_s;
  logic [7:0] iconst_off_s;
  logic [7:0] grp_off_s;
  logic [1:0] loadn_idx_s;
  logic [1:0] storen_idx_s;
  logic       unused_s;

  assign op_s         = instr[OPC_MSB:OPC_LSB];
  assign iconst_off_s = op_s - 8'h03;
  assign loadn_idx_s  = op_s[1:0] - 2'b10;
  assign storen_idx_s = op_s[1:0] - 2'b11;
  assign unused_s     = ^instr[7:0];

  // Offset of an lconst/fconst/dconst opcode from its own group base
  always_comb begin
    grp_off_s = 8'h00;
    if (op_s < OP_FCONST_LO) begin
      grp_off_s = op_s - OP_LCONST_LO;
    end else if (op_s < OP_DCONST_LO) begin
      grp_off_s = op_s - OP_FCONST_LO;
    end else begin
      grp_off_s = op_s - OP_DCONST_LO;
    end
  end

  // Opcode range table lookup
  always_comb begin
    cls    = CLS_UNSUPPORTED;
    length = 2'd1;
    valid  = 1'b1;
    imm    = 16'h0000;
    if (op_s == OP_NOP) begin
      cls = CLS_NOP;
    end else if (op_s == OP_ACONST_NULL) begin
      cls = CLS_CONST;
    end else if (op_s >= OP_ICONST_LO && op_s <= OP_ICONST_HI) begin
      cls = CLS_CONST;
      imm = {{8{iconst_off_s[7]}}, iconst_off_s};
    end else if (op_s >= OP_LCONST_LO && op_s <= OP_DCONST_HI) begin
      cls = CLS_CONST;
      imm = {8'h00, grp_off_s};
    end else if (op_s == OP_BIPUSH) begin
      cls    = CLS_CONST;
      length = 2'd2;
      imm    = {{8{instr[23]}}, instr[23:16]};
    end else if (op_s == OP_SIPUSH) begin
      cls    = CLS_CONST;
      length = 2'd3;
      imm    = instr[23:8];
    end else if (op_s >= OP_LOAD_LO && op_s <= OP_LOAD_HI) begin
      cls    = CLS_LOAD;
      length = 2'd2;
      imm    = {8'h00, instr[23:16]};
    end else if (op_s >= OP_LOADN_LO && op_s <= OP_LOADN_HI) begin
      cls = CLS_LOAD;
      imm = {14'd0, loadn_idx_s};
    end else if (op_s >= OP_ALOAD_LO && op_s <= OP_ALOAD_HI) begin
      cls = CLS_ALOAD;
    end else if (op_s >= OP_STORE_LO && op_s <= OP_STORE_HI) begin
      cls    = CLS_STORE;
      length = 2'd2;
      imm    = {8'h00, instr[23:16]};
    end else if (op_s >= OP_STOREN_LO && op_s <= OP_STOREN_HI) begin
      cls = CLS_STORE;
      imm = {14'd0, storen_idx_s};
    end else if (op_s >= OP_ASTORE_LO && op_s <= OP_ASTORE_HI) begin
      cls = CLS_ASTORE;
    end else if (op_s >= OP_STACK_LO && op_s <= OP_STACK_HI) begin
      cls = CLS_STACK;
    end else if (op_s >= OP_ARITH_LO && op_s <= OP_ARITH_HI) begin
      cls = CLS_ARITH;
    end else if (op_s == OP_IINC) begin
      cls    = CLS_IINC;
      length = 2'd3;
      imm    = instr[23:8];
    end else if (op_s >= OP_CONV_LO && op_s <= OP_CONV_HI) begin
      cls = CLS_CONVERT;
    end else if (op_s >= OP_CMP_LO && op_s <= OP_CMP_HI) begin
      cls = CLS_COMPARE;
    end else if (op_s >= OP_BRANCH_LO && op_s <= OP_BRANCH_HI) begin
      cls    = CLS_BRANCH;
      length = 2'd3;
      imm    = instr[23:8];
    end else begin
      cls   = CLS_UNSUPPORTED;
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/jvm_bytecode_decoder.sv
// Decode stage: IDLE/DECODE/SEND/DONE handshake FSM around the opcode classifier.
// Optional DECODER_TIMEOUT_EN aborts a SEND stalled with the wait counter at 7.
module jvm_bytecode_decoder
  import jvm_decoder_pkg::*;
#(
  parameter int BYTE      = 8,
  parameter int WIDTH_IN  = 4*BYTE,
  parameter int WIDTH_OUT = 4*BYTE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 ready,
  input  logic [WIDTH_IN-1:0]  instruction_in,
  output logic [WIDTH_OUT-1:0] instruction_out,
  output logic                 start_for_memory,
  input  logic                 ready_for_memory,
  output logic [2:0]           counter,
  output logic [1:0]           state,
  output logic [1:0]           next_state,
  output logic                 send,
  output logic                 done
);

  dec_state_e           state_r;
  dec_state_e           state_next_s;
  logic [WIDTH_IN-1:0]  instr_r;
  logic [WIDTH_OUT-1:0] instr_out_r;
  logic [2:0]           counter_r;
  logic                 done_r;
  logic                 ready_r;
  logic                 send_r;
  logic [3:0]           cls_s;
  logic [1:0]           len_s;
  logic                 valid_s;
  logic [15:0]          imm_s;
  logic [31:0]          decode_word_s;
  logic                 timeout_s;

  jvm_opcode_classifier u_classifier (
    .instr  (instr_r),
    .cls    (cls_s),
    .length (len_s),
    .valid  (valid_s),
    .imm    (imm_s)
  );

  assign decode_word_s = pack_decode(instr_r[OPC_MSB:OPC_LSB], cls_s, len_s, valid_s, imm_s);

`ifdef DECODER_TIMEOUT_EN
  assign timeout_s = (state_r == ST_SEND) && !ready_for_memory && (counter_r == 3'd7);
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_DECODE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_DECODE: state_next_s = ST_SEND;
      ST_SEND: begin
        if (ready_for_memory || timeout_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_SEND;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, datapath and status flags; flags are precomputed from next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      instr_r     <= '0;
      instr_out_r <= '0;
      counter_r   <= 3'd0;
      done_r      <= 1'b0;
      ready_r     <= 1'b1;
      send_r      <= 1'b0;
    end else begin
      state_r <= state_next_s;
      done_r  <= (state_next_s == ST_DONE);
      ready_r <= (state_next_s == ST_IDLE);
      send_r  <= (state_next_s == ST_SEND);
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            instr_r <= instruction_in;
          end
        end
        ST_DECODE: begin
          instr_out_r <= decode_word_s;
          counter_r   <= 3'd0;
        end
        ST_SEND: begin
          if (timeout_s) begin
            instr_out_r[VALID_BIT] <= 1'b0;
          end else if (!ready_for_memory && counter_r != 3'd7) begin
            counter_r <= counter_r + 3'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ready            = ready_r;
  assign send             = send_r;
  assign start_for_memory = send_r;
  assign done             = done_r;
  assign counter          = counter_r;
  assign instruction_out  = instr_out_r;
  assign state            = state_r;
  assign next_state       = state_next_s;

endmodule

// File: tb/tb_jvm_bytecode_decoder.sv
// Directed self-checking bench for jvm_bytecode_decoder with hand-computed
// decode words; also covers stall, saturation/timeout and reset in SEND.
module tb_jvm_bytecode_decoder;

  logic        clk;
  logic        reset;
  logic        start;
  logic        ready;
  logic [31:0] instruction_in;
  logic [31:0] instruction_out;
  logic        start_for_memory;
  logic        ready_for_memory;
  logic [2:0]  counter;
  logic [1:0]  state;
  logic [1:0]  next_state;
  logic        send;
  logic        done;

  int n_vec;
  int n_miss;

  logic [31:0] vin  [14];
  logic [31:0] vexp [14];

  jvm_bytecode_decoder dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .ready            (ready),
    .instruction_in   (instruction_in),
    .instruction_out  (instruction_out),
    .start_for_memory (start_for_memory),
    .ready_for_memory (ready_for_memory),
    .counter          (counter),
    .state            (state),
    .next_state       (next_state),
    .send             (send),
    .done             (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one instruction from IDLE with an immediate downstream accept.
  task automatic run_instr(input logic [31:0] word, input logic [31:0] exp);
    check_vec("ready_idle", 32'(ready), 32'd1);
    start            = 1'b1;
    instruction_in   = word;
    ready_for_memory = 1'b1;
    @(negedge clk);
    check_vec("st_decode", 32'(state), 32'd1);
    @(negedge clk);
    check_vec("st_send", 32'(state), 32'd2);
    check_vec($sformatf("out_%08h", word), instruction_out, exp);
    check_vec("sfm_send", 32'(start_for_memory), 32'd1);
    check_vec("ns_send", 32'(next_state), 32'd3);
    @(negedge clk);
    check_vec("st_done", 32'(state), 32'd3);
    check_vec("done_pulse", 32'(done), 32'd1);
    check_vec("ready_done", 32'(ready), 32'd0);
    @(negedge clk);
    check_vec("st_idle", 32'(state), 32'd0);
    check_vec("done_clear", 32'(done), 32'd0);
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    vin  = '{32'h0300_0000, 32'h0400_0000, 32'h6F00_0000, 32'h9100_0000,
             32'h5000_0000, 32'h10FF_0000, 32'hCA00_0000, 32'h0200_0000,
             32'h8401_0500, 32'h1B00_0000, 32'h1507_0000, 32'h0C00_0000,
             32'h99FF_F012, 32'h1112_3400};
    vexp = '{32'h0316_0000, 32'h0416_0001, 32'h6F76_0000, 32'h9186_0000,
             32'h5056_0000, 32'h101A_FFFF, 32'hCAF4_0000, 32'h0216_FFFF,
             32'h84BE_0105, 32'h1B26_0001, 32'h152A_0007, 32'h0C16_0001,
             32'h99AE_FFF0, 32'h111E_1234};

    reset            = 1'b1;
    start            = 1'b0;
    instruction_in   = 32'h0;
    ready_for_memory = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_vec("rst_state", 32'(state), 32'd0);
    check_vec("rst_ready", 32'(ready), 32'd1);
    check_vec("rst_sfm", 32'(start_for_memory), 32'd0);
    check_vec("rst_out", instruction_out, 32'h0);
    check_vec("rst_done", 32'(done), 32'd0);
    check_vec("rst_cnt", 32'(counter), 32'd0);
    reset = 1'b0;

    // back-to-back with start held high
    for (int i = 0; i < 14; i++) begin
      run_instr(vin[i], vexp[i]);
    end
    start = 1'b0;
    @(negedge clk);
    check_vec("idle_hold", 32'(state), 32'd0);

    // stall in SEND
    start            = 1'b1;
    instruction_in   = 32'h6F00_0000;
    ready_for_memory = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_vec("stall_cnt0", 32'(counter), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check_vec($sformatf("stall_cnt%0d", i), 32'(counter), 32'(i));
      check_vec("stall_out", instruction_out, 32'h6F76_0000);
      check_vec("stall_sfm", 32'(start_for_memory), 32'd1);
    end
    ready_for_memory = 1'b1;
    @(negedge clk);
    check_vec("stall_done", 32'(state), 32'd3);
    @(negedge clk);
    check_vec("stall_idle", 32'(state), 32'd0);

    // long stall: saturation or timeout
    start            = 1'b1;
    instruction_in   = 32'h0400_0000;
    ready_for_memory = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
`ifdef DECODER_TIMEOUT_EN
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      check_vec("to_cnt", 32'(counter), 32'(i));
    end
    @(negedge clk);
    check_vec("to_state", 32'(state), 32'd3);
    check_vec("to_out", instruction_out, 32'h0414_0001);
    check_vec("to_sfm", 32'(start_for_memory), 32'd0);
    @(negedge clk);
    check_vec("to_idle", 32'(state), 32'd0);
`else
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      check_vec("sat_cnt", 32'(counter), (i > 7) ? 32'd7 : 32'(i));
      check_vec("sat_state", 32'(state), 32'd2);
    end
    check_vec("sat_out", instruction_out, 32'h0416_0001);
    ready_for_memory = 1'b1;
    @(negedge clk);
    check_vec("sat_done", 32'(state), 32'd3);
    @(negedge clk);
    check_vec("sat_idle", 32'(state), 32'd0);
`endif

    // reset during SEND
    start            = 1'b1;
    instruction_in   = 32'h0300_0000;
    ready_for_memory = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_vec("rs_send", 32'(state), 32'd2);
    reset = 1'b1;
    @(negedge clk);
    check_vec("rs_state", 32'(state), 32'd0);
    check_vec("rs_sfm", 32'(start_for_memory), 32'd0);
    check_vec("rs_out", instruction_out, 32'h0);
    check_vec("rs_ready", 32'(ready), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
